// File: rtl/built_in_gates_sync.sv
// -----------------------------------------------------------------------------
// built_in_gates_sync
//
// Registered bank of primitive logic gates over three operand vectors.
// Every accepted beat (in_vld high at a rising clk edge) loads five bitwise
// results into output registers on that same edge. When in_vld is low, the
// results hold their previous values and out_vld drops.
//
// Parameters
//   WIDTH    bit width of a, b, c and of every result output (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous reset, active low (clears every output, including
//            the inverting gates o4/o10)
//   in_vld   operands a/b/c valid this cycle
//   a, b, c  operands, WIDTH bits each
//   o1       registered a & b & c
//   o2       registered a | b | c
//   o3       registered a ^ b ^ c (odd parity per bit)
//   o4       registered ~(a & b & c)
//   o10      registered ~(a | b | c)
//   out_vld  o1..o10 (and maj) hold the result of the beat accepted on the
//            most recent edge
//   maj      registered majority(a, b, c); present only when the macro
//            BUILT_IN_GATES_MAJ_EN is defined
//
// Configuration macro: BUILT_IN_GATES_MAJ_EN
//   defined   -> adds the maj output and its register
//   undefined -> no maj port and no majority logic
// -----------------------------------------------------------------------------
module built_in_gates_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o10,
    output logic             out_vld
`ifdef BUILT_IN_GATES_MAJ_EN
    ,
    output logic [WIDTH-1:0] maj
`endif
);

    // Combinational gate results, one slice per bit index. Bits never
    // interact, so each slice is built independently.
    logic [WIDTH-1:0] and_next;
    logic [WIDTH-1:0] or_next;
    logic [WIDTH-1:0] xor_next;
    logic [WIDTH-1:0] nand_next;
    logic [WIDTH-1:0] nor_next;

    // Output registers.
    logic [WIDTH-1:0] and_reg;
    logic [WIDTH-1:0] or_reg;
    logic [WIDTH-1:0] xor_reg;
    logic [WIDTH-1:0] nand_reg;
    logic [WIDTH-1:0] nor_reg;
    logic             vld_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_next[gi]  = a[gi] & b[gi] & c[gi];
            assign or_next[gi]   = a[gi] | b[gi] | c[gi];
            assign xor_next[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign nand_next[gi] = ~(a[gi] & b[gi] & c[gi]);
            assign nor_next[gi]  = ~(a[gi] | b[gi] | c[gi]);
        end
    endgenerate

    // Reset wins over in_vld in the same cycle; operands presented while
    // in reset are discarded. The inverting results reset to 0 as well,
    // because they are registers rather than gates on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            and_reg  <= '0;
            or_reg   <= '0;
            xor_reg  <= '0;
            nand_reg <= '0;
            nor_reg  <= '0;
        end else if (in_vld) begin
            and_reg  <= and_next;
            or_reg   <= or_next;
            xor_reg  <= xor_next;
            nand_reg <= nand_next;
            nor_reg  <= nor_next;
        end
    end

    // out_vld only marks the cycle right after an accepted beat; the result
    // registers themselves keep their value across idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_reg <= 1'b0;
        end else begin
            vld_reg <= in_vld;
        end
    end

    assign o1      = and_reg;
    assign o2      = or_reg;
    assign o3      = xor_reg;
    assign o4      = nand_reg;
    assign o10     = nor_reg;
    assign out_vld = vld_reg;

`ifdef BUILT_IN_GATES_MAJ_EN
    logic [WIDTH-1:0] maj_next;
    logic [WIDTH-1:0] maj_reg;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_maj_bit
            assign maj_next[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
        end
    endgenerate

    // Same load/hold/reset behaviour as the other result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            maj_reg <= '0;
        end else if (in_vld) begin
            maj_reg <= maj_next;
        end
    end

    assign maj = maj_reg;
`endif

endmodule

// File: tb/tb_built_in_gates_sync.sv
// -----------------------------------------------------------------------------
// tb_built_in_gates_sync
//
// Drives a WIDTH=1 and a WIDTH=4 instance of built_in_gates_sync with the same
// control signals. A reference model pushes the expected register contents to
// a scoreboard queue each time a beat is driven; each test task pops and
// compares once the edge has been taken. Known truth-table vectors are also
// compared against literal constants.
// -----------------------------------------------------------------------------
module tb_built_in_gates_sync;

    typedef struct packed {
        logic       vld;
        logic [3:0] o1;
        logic [3:0] o2;
        logic [3:0] o3;
        logic [3:0] o4;
        logic [3:0] o10;
        logic [3:0] maj;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_vld = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] c = '0;

    logic [0:0] n_o1, n_o2, n_o3, n_o4, n_o10, n_maj;
    logic       n_vld;
    logic [3:0] w_o1, w_o2, w_o3, w_o4, w_o10, w_maj;
    logic       w_vld;

    res_t model_reg = '0;
    res_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    built_in_gates_sync #(.WIDTH(1)) u_dut_n (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .a       (a[0:0]),
        .b       (b[0:0]),
        .c       (c[0:0]),
        .o1      (n_o1),
        .o2      (n_o2),
        .o3      (n_o3),
        .o4      (n_o4),
        .o10     (n_o10),
        .out_vld (n_vld)
`ifdef BUILT_IN_GATES_MAJ_EN
        ,
        .maj     (n_maj)
`endif
    );

    built_in_gates_sync #(.WIDTH(4)) u_dut_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .a       (a),
        .b       (b),
        .c       (c),
        .o1      (w_o1),
        .o2      (w_o2),
        .o3      (w_o3),
        .o4      (w_o4),
        .o10     (w_o10),
        .out_vld (w_vld)
`ifdef BUILT_IN_GATES_MAJ_EN
        ,
        .maj     (w_maj)
`endif
    );

`ifndef BUILT_IN_GATES_MAJ_EN
    assign n_maj = 1'b0;
    assign w_maj = 4'b0000;
`endif

    // Reference model: what the result registers hold after the coming edge.
    function automatic res_t next_model(res_t cur, logic rn, logic v,
                                        logic [3:0] ta, logic [3:0] tb, logic [3:0] tc);
        res_t r;
        if (!rn) begin
            r = '0;
        end else if (v) begin
            r.vld = 1'b1;
            r.o1  = ta & tb & tc;
            r.o2  = ta | tb | tc;
            r.o3  = ta ^ tb ^ tc;
            r.o4  = ~(ta & tb & tc);
            r.o10 = ~(ta | tb | tc);
`ifdef BUILT_IN_GATES_MAJ_EN
            r.maj = (ta & tb) | (ta & tc) | (tb & tc);
`else
            r.maj = 4'b0000;
`endif
        end else begin
            r = cur;
            r.vld = 1'b0;
        end
        return r;
    endfunction

    function automatic res_t obs_wide();
        res_t r;
        r.vld = w_vld;
        r.o1  = w_o1;
        r.o2  = w_o2;
        r.o3  = w_o3;
        r.o4  = w_o4;
        r.o10 = w_o10;
        r.maj = w_maj;
        return r;
    endfunction

    function automatic logic [6:0] obs_narrow();
        return {n_vld, n_o1, n_o2, n_o3, n_o4, n_o10, n_maj};
    endfunction

    function automatic logic [6:0] exp_narrow(res_t e);
        return {e.vld, e.o1[0], e.o2[0], e.o3[0], e.o4[0], e.o10[0], e.maj[0]};
    endfunction

    // Drive one cycle of stimulus, push the expectation, take the edge and
    // land 1 time unit after it so outputs are sampled away from the edge.
    task automatic drive(input logic rn, input logic v,
                         input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tc);
        @(negedge clk);
        rst_n  = rn;
        in_vld = v;
        a      = ta;
        b      = tb;
        c      = tc;
        model_reg = next_model(model_reg, rn, v, ta, tb, tc);
        exp_q.push_back(model_reg);
        @(posedge clk);
        #1;
        $display("beat rst_n=%b in_vld=%b a=%b b=%b c=%b -> w o1=%b o2=%b o3=%b o4=%b o10=%b maj=%b vld=%b",
                 rn, v, ta, tb, tc, w_o1, w_o2, w_o3, w_o4, w_o10, w_maj, w_vld);
    endtask

    task automatic test_reset();
        res_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 4'hF, 4'hF, 4'hF);
            e = exp_q.pop_front();
            checks++;
            if (obs_wide() !== e) $display("FAIL reset_wide cyc%0d got %h want %h", i, obs_wide(), e);
            else passed++;
            checks++;
            if (obs_narrow() !== exp_narrow(e)) $display("FAIL reset_narrow cyc%0d got %b want %b", i, obs_narrow(), exp_narrow(e));
            else passed++;
            checks++;
            if ({w_vld, w_o1, w_o2, w_o3, w_o4, w_o10} !== 21'd0)
                $display("FAIL reset_zero cyc%0d got %h want 0", i, {w_vld, w_o1, w_o2, w_o3, w_o4, w_o10});
            else passed++;
        end
    endtask

    // WIDTH=1 truth vectors, operands replicated across all four bits.
    task automatic test_gate_vectors();
        logic [2:0] abc_tab [5] = '{3'b101, 3'b010, 3'b001, 3'b111, 3'b000};
        logic [4:0] res_tab [5] = '{5'b01010, 5'b01110, 5'b01110, 5'b11100, 5'b00011};
        logic [1:0] maj_tab [5] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10}; // {used, value}
        res_t e;
        logic [2:0] v;
        for (int i = 0; i < 5; i++) begin
            v = abc_tab[i];
            drive(1'b1, 1'b1, {4{v[2]}}, {4{v[1]}}, {4{v[0]}});
            e = exp_q.pop_front();
            checks++;
            if (obs_wide() !== e) $display("FAIL gates_wide v%0d got %h want %h", i, obs_wide(), e);
            else passed++;
            checks++;
            if (obs_narrow() !== exp_narrow(e)) $display("FAIL gates_narrow v%0d got %b want %b", i, obs_narrow(), exp_narrow(e));
            else passed++;
            checks++;
            if ({n_vld, n_o1, n_o2, n_o3, n_o4, n_o10} !== {1'b1, res_tab[i]})
                $display("FAIL gates_table v%0d got %b want %b", i, {n_vld, n_o1, n_o2, n_o3, n_o4, n_o10}, {1'b1, res_tab[i]});
            else passed++;
`ifdef BUILT_IN_GATES_MAJ_EN
            checks++;
            if (n_maj[0] !== maj_tab[i][0]) $display("FAIL maj_table v%0d got %b want %b", i, n_maj, maj_tab[i][0]);
            else passed++;
`else
            if (maj_tab[i][1] !== 1'b1) $display("note: maj table entry %0d unused", i);
`endif
        end
    endtask

    // After a=b=c=0, idle cycles with changing (and unknown) operands hold.
    task automatic test_hold();
        res_t e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
            else        drive(1'b1, 1'b0, 4'bxxxx, 4'bzzzz, 4'hA);
            e = exp_q.pop_front();
            checks++;
            if (obs_wide() !== e) $display("FAIL hold_wide cyc%0d got %h want %h", i, obs_wide(), e);
            else passed++;
            checks++;
            if ({n_vld, n_o1, n_o2, n_o3, n_o4, n_o10} !== 6'b000011)
                $display("FAIL hold_narrow cyc%0d got %b want 000011", i, {n_vld, n_o1, n_o2, n_o3, n_o4, n_o10});
            else passed++;
        end
    endtask

    task automatic test_wide();
        res_t e;
        drive(1'b1, 1'b1, 4'b1100, 4'b1010, 4'b1001);
        e = exp_q.pop_front();
        checks++;
        if (obs_wide() !== e) $display("FAIL wide_model got %h want %h", obs_wide(), e);
        else passed++;
        checks++;
        if ({w_o1, w_o2, w_o3, w_o4, w_o10} !== {4'b1000, 4'b1111, 4'b1111, 4'b0111, 4'b0000})
            $display("FAIL wide_table got %b want 10001111111101110000", {w_o1, w_o2, w_o3, w_o4, w_o10});
        else passed++;
    endtask

    // Random stream with occasional idle cycles; every beat must land.
    task automatic test_back_to_back();
        res_t e;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 4'($urandom));
            e = exp_q.pop_front();
            checks++;
            if (obs_wide() !== e) $display("FAIL b2b_wide beat%0d got %h want %h", i, obs_wide(), e);
            else passed++;
            checks++;
            if (obs_narrow() !== exp_narrow(e)) $display("FAIL b2b_narrow beat%0d got %b want %b", i, obs_narrow(), exp_narrow(e));
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        res_t e;
        logic [3:0] sa [4] = '{4'hF, 4'h6, 4'h3, 4'hC};
        logic [3:0] sb [4] = '{4'hF, 4'h5, 4'h9, 4'h3};
        logic [3:0] sc [4] = '{4'hF, 4'h3, 4'h6, 4'h5};
        logic       sr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(sr[i], 1'b1, sa[i], sb[i], sc[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_wide() !== e) $display("FAIL midrst_wide step%0d got %h want %h", i, obs_wide(), e);
            else passed++;
            checks++;
            if (obs_narrow() !== exp_narrow(e)) $display("FAIL midrst_narrow step%0d got %b want %b", i, obs_narrow(), exp_narrow(e));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_gate_vectors();
        test_hold();
        test_wide();
        test_back_to_back();
        test_reset_midstream();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
